mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback stage. Registers one beat per cycle from the memory stage,
//  selects writeback data (memory read data vs ALU result), and drives the register-file write port.
//  Assembles a PC_W-bit return PC from two consecutive DATA_W-bit stack pops (RET/RTI) with a small FSM.
//  Issues a one-cycle pc_load pulse to fetch.
// PARAMETERS
//  DATA_W      16  data / memory word width
//  REG_ADDR_W  3   register-file address width (8 registers)
//  PC_W        32  PC width; must equal 2*DATA_W
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-low
//  in_valid     in   1           beat from memory stage is valid
//  stall        in   1           hold; no beat accepted, all state frozen
//  flush        in   1           discard beat in flight and abort any PC pop
//  mem_to_reg   in   1           1: writeback mem_data, 0: writeback alu_result
//  reg_write    in   1           beat writes the register file
//  rdst         in   REG_ADDR_W  destination register
//  alu_result   in   DATA_W      ALU result passed through memory stage
//  mem_data     in   DATA_W      data read by memory stage
//  pc_pop       in   1           beat carries one half of a popped PC (high half first)
//  wb_en        out  1           register-file write enable (1-cycle pulse per beat)
//  wb_addr      out  REG_ADDR_W  register-file write address
//  wb_data      out  DATA_W      register-file write data, also forwarding source
//  pc_load      out  1           1-cycle pulse: load pc_value into PC
//  pc_value     out  PC_W        assembled return PC {hi, lo}
//  pop_busy     out  1           high half captured, waiting for low half
//  pop_err      out  1           sticky protocol error flag, cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): wb_en=0, wb_addr=0, wb_data=0, pc_load=0, pc_value=0, pop_busy=0, pop_err=0.
//    Reset also sets FSM=IDLE and clears the internal hi register.
//  - Beat accepted on a rising edge when in_valid=1, stall=0, flush=0. All outputs are registered.
//    Latency from accepted beat to wb_en/pc_load is 1 cycle.
//  - Priority: reset > flush > stall > accept.
//  - Normal beat (pc_pop=0): next cycle wb_en=reg_write, wb_addr=rdst,
//    wb_data=mem_to_reg ? mem_data : alu_result.
//  - wb_en and pc_load are pulses. They are 0 in any cycle after a non-accepted edge (stall, flush, !in_valid).
//    wb_addr and wb_data hold their last values.
//  - pc_pop beats never assert wb_en, regardless of reg_write.
//  - FSM states: IDLE, GOT_HI.
//    IDLE + accepted pc_pop beat -> GOT_HI; hi <= mem_data; pop_busy=1 next cycle.
//    GOT_HI + accepted pc_pop beat -> IDLE; next cycle pc_load=1, pc_value={hi, mem_data}, pop_busy=0.
//    GOT_HI + accepted beat with pc_pop=0 -> IDLE; pop_err<=1; hi discarded.
//      That beat still writes back as a normal beat.
//    GOT_HI + idle cycles (in_valid=0) or stall -> stay in GOT_HI; no timeout.
//  - Flush: next cycle wb_en=0 and pc_load=0; FSM -> IDLE; pop_busy=0; pop_err unchanged.
//    Flush and stall in the same cycle: flush wins.
//  - pc_value holds until the next pc_load; it is not cleared by flush.
//  - Back-to-back beats: one accepted per cycle, no bubbles inserted.
// TESTING
//  1. Reset: rst low mid-cycle -> all outputs 0 immediately, before any clock edge.
//  2. ALU writeback: reg_write=1, rdst=5, alu_result=16'h1234, mem_to_reg=0
//     -> next cycle wb_en=1, wb_addr=5, wb_data=16'h1234; following cycle wb_en=0.
//  3. Load under stall: mem_data=16'hBEEF, mem_to_reg=1, stall=1 for 2 cycles, then stall=0
//     -> wb_en stays 0 during the stall; 1 cycle after release wb_en=1, wb_data=16'hBEEF.
//  4. RET pop: pc_pop beats 16'h0001 then 16'h00A0 on consecutive cycles
//     -> pop_busy=1 for one cycle; then pc_load=1, pc_value=32'h000100A0; wb_en=0 throughout.
//  5. Flush mid-pop: pc_pop hi=16'h0002, then flush=1 -> pop_busy=0, no pc_load.
//     Next pop pair 16'h0003/16'h0004 -> pc_value=32'h00030004.
//  6. Protocol error: pc_pop hi, then normal beat rdst=2, alu_result=7
//     -> pop_err=1 (sticky), wb_en=1, wb_addr=2, wb_data=7, no pc_load.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB bus: memory-stage beat inputs plus writeback and PC-load outputs.
// The master drives beats into the stage; the slave is the stage itself.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned PC_W       = 32
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rdst;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     mem_data;
  logic                  pc_pop;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  pc_load;
  logic [PC_W-1:0]       pc_value;
  logic                  pop_busy;
  logic                  pop_err;

  modport master (
    output in_valid, stall, flush, mem_to_reg, reg_write, rdst, alu_result, mem_data, pc_pop,
    input  wb_en, wb_addr, wb_data, pc_load, pc_value, pop_busy, pop_err
  );

  modport slave (
    input  in_valid, stall, flush, mem_to_reg, reg_write, rdst, alu_result, mem_data, pc_pop,
    output wb_en, wb_addr, wb_data, pc_load, pc_value, pop_busy, pop_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage; also assembles a return PC
// from two consecutive stack-pop beats (high half first) and pulses pc_load.
module mem_wb_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned PC_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GOT_HI = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  pc_load_q, pc_load_d;
  logic [PC_W-1:0]       pc_value_q, pc_value_d;
  logic                  pop_busy_q, pop_busy_d;
  logic                  pop_err_q, pop_err_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic                  accept_c;

  assign accept_c = bus.in_valid & ~bus.stall & ~bus.flush;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: flush aborts a pop; any accepted beat in GOT_HI returns to IDLE
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (accept_c) begin
      case (state_q)
        IDLE:    if (bus.pc_pop) state_d = GOT_HI;
        GOT_HI:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next output values; pulses default low, data outputs hold
  always_comb begin
    wb_en_d    = 1'b0;
    pc_load_d  = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    pc_value_d = pc_value_q;
    pop_err_d  = pop_err_q;
    hi_d       = hi_q;
    pop_busy_d = (state_d == GOT_HI);
    if (accept_c) begin
      if (!bus.pc_pop) begin
        wb_en_d   = bus.reg_write;
        wb_addr_d = bus.rdst;
        wb_data_d = bus.mem_to_reg ? bus.mem_data : bus.alu_result;
        if (state_q == GOT_HI) begin
          pop_err_d = 1'b1;
          hi_d      = '0;
        end
      end else if (state_q == IDLE) begin
        hi_d = bus.mem_data;
      end else begin
        pc_load_d  = 1'b1;
        pc_value_d = PC_W'({hi_q, bus.mem_data});
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
      pop_busy_q <= 1'b0;
      pop_err_q  <= 1'b0;
      hi_q       <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
      pop_busy_q <= pop_busy_d;
      pop_err_q  <= pop_err_d;
      hi_q       <= hi_d;
    end
  end

  assign bus.wb_en    = wb_en_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_value = pc_value_q;
  assign bus.pop_busy = pop_busy_q;
  assign bus.pop_err  = pop_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: writeback, stall, PC pop pairs, flush,
// protocol error and asynchronous reset, with hand-computed expectations.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned PC_W       = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  mem_wb_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) bus ();

  mem_wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.rdst       = '0;
    bus.alu_result = '0;
    bus.mem_data   = '0;
    bus.pc_pop     = 1'b0;
  endtask

  task automatic pop_beat(input logic [DATA_W-1:0] d);
    bus.in_valid  = 1'b1;
    bus.pc_pop    = 1'b1;
    bus.reg_write = 1'b1;
    bus.mem_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_pc_value", 64'(bus.pc_value), 64'd0);
    chk("rst_pop_busy", 64'(bus.pop_busy), 64'd0);
    rst = 1'b1;
    cyc();

    // ALU writeback
    bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.rdst = 3'd5;
    bus.alu_result = 16'h1234; bus.mem_data = 16'h5555; bus.mem_to_reg = 1'b0;
    cyc();
    chk("alu_wb_en", 64'(bus.wb_en), 64'd1);
    chk("alu_wb_addr", 64'(bus.wb_addr), 64'd5);
    chk("alu_wb_data", 64'(bus.wb_data), 64'h1234);
    idle_inputs();
    cyc();
    chk("alu_wb_en_pulse", 64'(bus.wb_en), 64'd0);
    chk("alu_wb_data_hold", 64'(bus.wb_data), 64'h1234);

    // Load held by stall for two cycles
    bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.rdst = 3'd3;
    bus.mem_to_reg = 1'b1; bus.mem_data = 16'hBEEF; bus.alu_result = 16'h0F0F; bus.stall = 1'b1;
    cyc();
    chk("stall1_wb_en", 64'(bus.wb_en), 64'd0);
    cyc();
    chk("stall2_wb_en", 64'(bus.wb_en), 64'd0);
    chk("stall2_wb_data", 64'(bus.wb_data), 64'h1234);
    bus.stall = 1'b0;
    cyc();
    chk("load_wb_en", 64'(bus.wb_en), 64'd1);
    chk("load_wb_addr", 64'(bus.wb_addr), 64'd3);
    chk("load_wb_data", 64'(bus.wb_data), 64'hBEEF);

    // Back-to-back normal beats
    bus.mem_to_reg = 1'b0; bus.rdst = 3'd6; bus.alu_result = 16'hA5A5;
    cyc();
    chk("b2b1_wb_data", 64'(bus.wb_data), 64'hA5A5);
    bus.rdst = 3'd7; bus.alu_result = 16'h5A5A; bus.reg_write = 1'b0;
    cyc();
    chk("b2b2_wb_en", 64'(bus.wb_en), 64'd0);
    chk("b2b2_wb_addr", 64'(bus.wb_addr), 64'd7);
    chk("b2b2_wb_data", 64'(bus.wb_data), 64'h5A5A);
    idle_inputs();
    cyc();

    // RET pop pair
    pop_beat(16'h0001);
    cyc();
    chk("ret_hi_busy", 64'(bus.pop_busy), 64'd1);
    chk("ret_hi_wb_en", 64'(bus.wb_en), 64'd0);
    chk("ret_hi_pc_load", 64'(bus.pc_load), 64'd0);
    pop_beat(16'h00A0);
    cyc();
    chk("ret_lo_pc_load", 64'(bus.pc_load), 64'd1);
    chk("ret_lo_pc_value", 64'(bus.pc_value), 64'h000100A0);
    chk("ret_lo_busy", 64'(bus.pop_busy), 64'd0);
    chk("ret_lo_wb_en", 64'(bus.wb_en), 64'd0);
    chk("ret_lo_wb_data", 64'(bus.wb_data), 64'h5A5A);
    idle_inputs();
    cyc();
    chk("ret_pc_load_pulse", 64'(bus.pc_load), 64'd0);
    chk("ret_pc_value_hold", 64'(bus.pc_value), 64'h000100A0);

    // Flush mid-pop, then a fresh pair
    pop_beat(16'h0002);
    cyc();
    chk("fl_hi_busy", 64'(bus.pop_busy), 64'd1);
    pop_beat(16'h0009);
    bus.flush = 1'b1;
    cyc();
    chk("fl_busy", 64'(bus.pop_busy), 64'd0);
    chk("fl_pc_load", 64'(bus.pc_load), 64'd0);
    chk("fl_pc_value", 64'(bus.pc_value), 64'h000100A0);
    bus.flush = 1'b0;
    pop_beat(16'h0003);
    cyc();
    chk("fl2_hi_busy", 64'(bus.pop_busy), 64'd1);
    pop_beat(16'h0004);
    cyc();
    chk("fl2_pc_load", 64'(bus.pc_load), 64'd1);
    chk("fl2_pc_value", 64'(bus.pc_value), 64'h00030004);
    chk("fl2_pop_err", 64'(bus.pop_err), 64'd0);

    // Idle and stall keep GOT_HI; flush+stall still aborts
    pop_beat(16'h0011);
    cyc();
    idle_inputs();
    cyc();
    chk("wait_idle_busy", 64'(bus.pop_busy), 64'd1);
    pop_beat(16'h0022);
    bus.stall = 1'b1;
    cyc();
    chk("wait_stall_busy", 64'(bus.pop_busy), 64'd1);
    chk("wait_stall_pc_load", 64'(bus.pc_load), 64'd0);
    bus.flush = 1'b1;
    cyc();
    chk("fl_stall_busy", 64'(bus.pop_busy), 64'd0);
    idle_inputs();
    cyc();

    // Protocol error: normal beat after the high half
    pop_beat(16'h0008);
    cyc();
    bus.pc_pop = 1'b0; bus.reg_write = 1'b1; bus.rdst = 3'd2;
    bus.alu_result = 16'd7; bus.mem_data = 16'h0099; bus.mem_to_reg = 1'b0;
    cyc();
    chk("err_pop_err", 64'(bus.pop_err), 64'd1);
    chk("err_wb_en", 64'(bus.wb_en), 64'd1);
    chk("err_wb_addr", 64'(bus.wb_addr), 64'd2);
    chk("err_wb_data", 64'(bus.wb_data), 64'd7);
    chk("err_pc_load", 64'(bus.pc_load), 64'd0);
    chk("err_busy", 64'(bus.pop_busy), 64'd0);
    bus.flush = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    chk("err_sticky", 64'(bus.pop_err), 64'd1);

    // Asynchronous reset asserted mid-cycle
    #3;
    rst = 1'b0;
    #1;
    chk("arst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("arst_wb_addr", 64'(bus.wb_addr), 64'd0);
    chk("arst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("arst_pc_load", 64'(bus.pc_load), 64'd0);
    chk("arst_pc_value", 64'(bus.pc_value), 64'd0);
    chk("arst_pop_busy", 64'(bus.pop_busy), 64'd0);
    chk("arst_pop_err", 64'(bus.pop_err), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
